// File: rtl/dcache_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dcache_ctrl_pkg
//  Description : Shared definitions for the direct-mapped write-back data
//                cache: default geometry, line-fill FSM state encoding and a
//                tag-width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package dcache_ctrl_pkg;

  // Default cache geometry
  localparam int c_def_line_words = 4;
  localparam int c_def_line_num   = 64;

  // Line-fill FSM state encoding
  typedef enum logic [1:0] {
    DC_IDLE = 2'd0,
    DC_WB   = 2'd1,
    DC_FILL = 2'd2,
    DC_DONE = 2'd3
  } dc_state_e;

  // Tag width left over after word offset, line offset and index bits
  function automatic int dc_tag_w(input int line_words, input int line_num);
    return 30 - $clog2(line_words) - $clog2(line_num);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dcache_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : dcache_cpu_if / dcache_mem_if
//  Description : Bus bundles for the data cache.
//                dcache_cpu_if : MEM-stage request port. master = pipeline,
//                                slave = cache.
//                  cpu_ren, cpu_wen, cpu_addr, cpu_din  (pipeline -> cache)
//                  cpu_dout, cpu_stall                  (cache -> pipeline)
//                dcache_mem_if : word-wide main-memory beat bus. master =
//                                cache, slave = memory.
//                  mem_cs, mem_we, mem_addr, mem_dout   (cache -> memory)
//                  mem_din, mem_ack                     (memory -> cache)
//  Revision    : 1.0 - initial release
// ============================================================================
interface dcache_cpu_if;
  logic        cpu_ren;
  logic        cpu_wen;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_din;
  logic [31:0] cpu_dout;
  logic        cpu_stall;

  modport master (
    output cpu_ren, cpu_wen, cpu_addr, cpu_din,
    input  cpu_dout, cpu_stall
  );

  modport slave (
    input  cpu_ren, cpu_wen, cpu_addr, cpu_din,
    output cpu_dout, cpu_stall
  );
endinterface

interface dcache_mem_if;
  logic        mem_cs;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_dout;
  logic [31:0] mem_din;
  logic        mem_ack;

  modport master (
    output mem_cs, mem_we, mem_addr, mem_dout,
    input  mem_din, mem_ack
  );

  modport slave (
    input  mem_cs, mem_we, mem_addr, mem_dout,
    output mem_din, mem_ack
  );
endinterface
`default_nettype wire

// File: rtl/dcache_line_ram.sv
`default_nettype none
// ============================================================================
//  Module      : dcache_line_ram
//  Description : Storage for the direct-mapped cache: data words, tags and
//                valid/dirty bits. Synchronous write, asynchronous read.
//                A single write port serves both CPU stores and fill beats;
//                the line being written is always the one selected by i_idx.
//  Ports       : clk, rst        clock / synchronous reset (clears valid+dirty)
//                i_idx           line index for lookup and writes
//                i_rd_off        word offset of the CPU read word
//                i_wb_off        word offset of the victim write-back word
//                o_line_*        tag / valid / dirty of the indexed line
//                o_rd_word       word at {i_idx, i_rd_off}
//                o_wb_word       word at {i_idx, i_wb_off}
//                i_wr_en         write i_wr_data to {i_idx, i_wr_off}
//                i_wr_tag_en     install i_wr_tag, valid=1, dirty=0
//                i_wr_dirty      mark line dirty
//  Revision    : 1.0 - initial release
// ============================================================================
module dcache_line_ram #(
  parameter int OFF_W = 2,
  parameter int IDX_W = 6,
  parameter int TAG_W = 22
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic [IDX_W-1:0] i_idx,
  input  wire logic [OFF_W-1:0] i_rd_off,
  input  wire logic [OFF_W-1:0] i_wb_off,
  output logic      [TAG_W-1:0] o_line_tag,
  output logic                  o_line_valid,
  output logic                  o_line_dirty,
  output logic      [31:0]      o_rd_word,
  output logic      [31:0]      o_wb_word,
  input  wire logic             i_wr_en,
  input  wire logic             i_wr_tag_en,
  input  wire logic             i_wr_dirty,
  input  wire logic [OFF_W-1:0] i_wr_off,
  input  wire logic [31:0]      i_wr_data,
  input  wire logic [TAG_W-1:0] i_wr_tag
);

  localparam int c_lines = 1 << IDX_W;
  localparam int c_words = 1 << (IDX_W + OFF_W);

  logic [31:0]      r_data  [c_words];
  logic [TAG_W-1:0] r_tag   [c_lines];
  logic [c_lines-1:0] r_valid;
  logic [c_lines-1:0] r_dirty;

  assign o_line_tag   = r_tag[i_idx];
  assign o_line_valid = r_valid[i_idx];
  assign o_line_dirty = r_dirty[i_idx];
  assign o_rd_word    = r_data[{i_idx, i_rd_off}];
  assign o_wb_word    = r_data[{i_idx, i_wb_off}];

  // Data and tags carry no reset: a line is meaningless until valid is set.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_data[{i_idx, i_wr_off}] <= i_wr_data;
    end
    if (i_wr_tag_en) begin
      r_tag[i_idx] <= i_wr_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (i_wr_tag_en) begin
      r_valid[i_idx] <= 1'b1;
      r_dirty[i_idx] <= 1'b0;
    end else if (i_wr_dirty) begin
      r_dirty[i_idx] <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dcache_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : dcache_ctrl
//  Description : Direct-mapped, write-back, write-allocate data cache between
//                the MEM-stage port and a word-wide memory bus. Hits complete
//                in the request cycle; a miss stalls the pipeline while the
//                FSM writes back a dirty victim and refills the line one word
//                per memory beat, then replays the request in DONE.
//  Ports       : clk, rst        clock / synchronous active-high reset
//                cpu             dcache_cpu_if.slave  (MEM-stage port)
//                mem             dcache_mem_if.master (memory beat bus)
//                stat_hit/miss   hit / miss counters (DCACHE_STAT_EN only)
//  Config      : `define DCACHE_STAT_EN adds the stat_hit/stat_miss outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module dcache_ctrl
  import dcache_ctrl_pkg::*;
#(
  parameter int LINE_WORDS = c_def_line_words,
  parameter int LINE_NUM   = c_def_line_num
) (
  input  wire logic    clk,
  input  wire logic    rst,
  dcache_cpu_if.slave  cpu,
  dcache_mem_if.master mem
`ifdef DCACHE_STAT_EN
  ,
  output logic [31:0]  stat_hit,
  output logic [31:0]  stat_miss
`endif
);

  localparam int c_off_w = $clog2(LINE_WORDS);
  localparam int c_idx_w = $clog2(LINE_NUM);
  localparam int c_tag_w = dc_tag_w(LINE_WORDS, LINE_NUM);
  localparam logic [c_off_w-1:0] c_last_beat = c_off_w'(LINE_WORDS - 1);

  // Address split
  logic [c_off_w-1:0] w_off;
  logic [c_idx_w-1:0] w_idx;
  logic [c_tag_w-1:0] w_tag;
  logic [1:0]         w_unused_addr_lsb;

  assign w_off             = cpu.cpu_addr[c_off_w+1:2];
  assign w_idx             = cpu.cpu_addr[c_idx_w+c_off_w+1:c_off_w+2];
  assign w_tag             = cpu.cpu_addr[31:c_idx_w+c_off_w+2];
  assign w_unused_addr_lsb = cpu.cpu_addr[1:0];

  // State and registered memory-bus outputs
  dc_state_e          r_state;
  logic [c_off_w-1:0] r_beat;
  logic               r_mem_cs;
  logic               r_mem_we;
  logic [31:0]        r_mem_addr;
  logic [31:0]        r_mem_dout;

  // Line storage
  logic [c_tag_w-1:0] w_line_tag;
  logic               w_line_valid;
  logic               w_line_dirty;
  logic [31:0]        w_rd_word;
  logic [31:0]        w_wb_word;
  logic [c_off_w-1:0] w_wb_off;
  logic               w_wr_en;
  logic               w_wr_tag_en;
  logic               w_wr_dirty;
  logic [c_off_w-1:0] w_wr_off;
  logic [31:0]        w_wr_data;

  logic               w_req;
  logic               w_hit;
  logic               w_beat_done;
  logic               w_last_beat;
  logic [c_off_w-1:0] w_beat_nxt;
  logic               w_stall;
  logic [31:0]        w_dout;

  assign w_req       = cpu.cpu_ren | cpu.cpu_wen;
  assign w_hit       = w_line_valid && (w_line_tag == w_tag);
  // An ack with no beat outstanding is not a completion.
  assign w_beat_done = r_mem_cs & mem.mem_ack;
  assign w_last_beat = (r_beat == c_last_beat);
  assign w_beat_nxt  = r_beat + 1'b1;

  // The write-back word is registered onto mem_dout one beat ahead: word 0
  // when leaving IDLE, word beat+1 on each WB ack.
  assign w_wb_off = (r_state == DC_WB) ? w_beat_nxt : '0;

  dcache_line_ram #(
    .OFF_W (c_off_w),
    .IDX_W (c_idx_w),
    .TAG_W (c_tag_w)
  ) u_line_ram (
    .clk          (clk),
    .rst          (rst),
    .i_idx        (w_idx),
    .i_rd_off     (w_off),
    .i_wb_off     (w_wb_off),
    .o_line_tag   (w_line_tag),
    .o_line_valid (w_line_valid),
    .o_line_dirty (w_line_dirty),
    .o_rd_word    (w_rd_word),
    .o_wb_word    (w_wb_word),
    .i_wr_en      (w_wr_en),
    .i_wr_tag_en  (w_wr_tag_en),
    .i_wr_dirty   (w_wr_dirty),
    .i_wr_off     (w_wr_off),
    .i_wr_data    (w_wr_data),
    .i_wr_tag     (w_tag)
  );

  // Single write port: CPU store on an IDLE hit or DONE replay, fill word
  // on each FILL ack (tag installed with the last one).
  always_comb begin
    w_wr_en     = 1'b0;
    w_wr_tag_en = 1'b0;
    w_wr_dirty  = 1'b0;
    w_wr_off    = w_off;
    w_wr_data   = cpu.cpu_din;
    case (r_state)
      DC_IDLE: begin
        if (cpu.cpu_wen && w_hit) begin
          w_wr_en    = 1'b1;
          w_wr_dirty = 1'b1;
        end
      end
      DC_FILL: begin
        if (w_beat_done) begin
          w_wr_en     = 1'b1;
          w_wr_off    = r_beat;
          w_wr_data   = mem.mem_din;
          w_wr_tag_en = w_last_beat;
        end
      end
      DC_DONE: begin
        if (cpu.cpu_wen) begin
          w_wr_en    = 1'b1;
          w_wr_dirty = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Stall and load data
  always_comb begin
    w_stall = 1'b0;
    w_dout  = '0;
    case (r_state)
      DC_IDLE: begin
        w_stall = w_req & ~w_hit;
        if (w_req && w_hit) begin
          w_dout = w_rd_word;
        end
      end
      DC_WB, DC_FILL: w_stall = 1'b1;
      DC_DONE:        w_dout  = w_rd_word;
      default: ;
    endcase
  end

  assign cpu.cpu_stall = w_stall;
  assign cpu.cpu_dout  = w_dout;
  assign mem.mem_cs    = r_mem_cs;
  assign mem.mem_we    = r_mem_we;
  assign mem.mem_addr  = r_mem_addr;
  assign mem.mem_dout  = r_mem_dout;

  // Line-fill FSM. The beat counter wraps to 0 after the last beat, so it
  // is already cleared on every state exit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= DC_IDLE;
      r_beat     <= '0;
      r_mem_cs   <= 1'b0;
      r_mem_we   <= 1'b0;
      r_mem_addr <= '0;
      r_mem_dout <= '0;
    end else begin
      case (r_state)
        DC_IDLE: begin
          if (w_req && !w_hit) begin
            r_mem_cs <= 1'b1;
            if (w_line_valid && w_line_dirty) begin
              r_state    <= DC_WB;
              r_mem_we   <= 1'b1;
              r_mem_addr <= {w_line_tag, w_idx, {c_off_w{1'b0}}, 2'b00};
              r_mem_dout <= w_wb_word;
            end else begin
              r_state    <= DC_FILL;
              r_mem_we   <= 1'b0;
              r_mem_addr <= {w_tag, w_idx, {c_off_w{1'b0}}, 2'b00};
              r_mem_dout <= '0;
            end
          end
        end
        DC_WB: begin
          if (w_beat_done) begin
            r_beat <= w_beat_nxt;
            if (w_last_beat) begin
              r_state    <= DC_FILL;
              r_mem_we   <= 1'b0;
              r_mem_addr <= {w_tag, w_idx, {c_off_w{1'b0}}, 2'b00};
              r_mem_dout <= '0;
            end else begin
              r_mem_addr <= {w_line_tag, w_idx, w_beat_nxt, 2'b00};
              r_mem_dout <= w_wb_word;
            end
          end
        end
        DC_FILL: begin
          if (w_beat_done) begin
            r_beat <= w_beat_nxt;
            if (w_last_beat) begin
              r_state    <= DC_DONE;
              r_mem_cs   <= 1'b0;
              r_mem_addr <= '0;
            end else begin
              r_mem_addr <= {w_tag, w_idx, w_beat_nxt, 2'b00};
            end
          end
        end
        DC_DONE: begin
          r_state <= DC_IDLE;
        end
        default: begin
          r_state <= DC_IDLE;
        end
      endcase
    end
  end

`ifdef DCACHE_STAT_EN
  logic [31:0] r_stat_hit;
  logic [31:0] r_stat_miss;

  // Only IDLE lookups count; the DONE replay is part of the miss.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_hit  <= '0;
      r_stat_miss <= '0;
    end else if (r_state == DC_IDLE && w_req) begin
      if (w_hit) begin
        r_stat_hit <= r_stat_hit + 32'd1;
      end else begin
        r_stat_miss <= r_stat_miss + 32'd1;
      end
    end
  end

  assign stat_hit  = r_stat_hit;
  assign stat_miss = r_stat_miss;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dcache_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dcache_ctrl
//  Description : Self-checking bench for dcache_ctrl. Table-driven hit
//                vectors plus directed miss / write-back / latency / reset
//                sequences against a behavioural word memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dcache_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dcache_cpu_if cpu_bus();
  dcache_mem_if mem_bus();

`ifdef DCACHE_STAT_EN
  logic [31:0] stat_hit;
  logic [31:0] stat_miss;
`endif

  dcache_ctrl #(
    .LINE_WORDS (4),
    .LINE_NUM   (64)
  ) dut (
    .clk (clk),
    .rst (rst),
    .cpu (cpu_bus),
    .mem (mem_bus)
`ifdef DCACHE_STAT_EN
    ,
    .stat_hit  (stat_hit),
    .stat_miss (stat_miss)
`endif
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // ---------------- behavioural memory with configurable ack latency -------
  logic [31:0] mem_store [logic [31:0]];
  logic        log_we   [$];
  logic [31:0] log_addr [$];
  logic [31:0] log_data [$];
  int          lat      = 1;
  int          wait_cnt = 0;
  int          held_err = 0;
  logic        hold_we;
  logic [31:0] hold_addr;
  logic [31:0] hold_dout;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem_store.exists(a)) return mem_store[a];
    return a ^ 32'hC0DE_0000;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      mem_bus.mem_ack = 1'b0;
      mem_bus.mem_din = '0;
      wait_cnt = 0;
    end else begin
      if (mem_bus.mem_ack) begin
        mem_bus.mem_ack = 1'b0;
        wait_cnt = 0;
      end
      if (mem_bus.mem_cs) begin
        if (wait_cnt == 0) begin
          hold_we   = mem_bus.mem_we;
          hold_addr = mem_bus.mem_addr;
          hold_dout = mem_bus.mem_dout;
        end else if (hold_we !== mem_bus.mem_we || hold_addr !== mem_bus.mem_addr ||
                     (hold_we && hold_dout !== mem_bus.mem_dout)) begin
          held_err++;
        end
        wait_cnt++;
        if (wait_cnt >= lat) begin
          mem_bus.mem_ack = 1'b1;
          log_we.push_back(mem_bus.mem_we);
          log_addr.push_back(mem_bus.mem_addr);
          if (mem_bus.mem_we) begin
            mem_store[mem_bus.mem_addr] = mem_bus.mem_dout;
            log_data.push_back(mem_bus.mem_dout);
          end else begin
            mem_bus.mem_din = mem_rd(mem_bus.mem_addr);
            log_data.push_back(mem_bus.mem_din);
          end
        end
      end
    end
  end

  // ---------------- CPU request driver -------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; samples at posedge+4; returns at posedge+1 after
  // the cycle in which the stall dropped.
  task automatic run_req(input string name, input logic ren, input logic wen,
                         input logic [31:0] addr, input logic [31:0] din,
                         output int stalls, output logic [31:0] dout);
    cpu_bus.cpu_ren  = ren;
    cpu_bus.cpu_wen  = wen;
    cpu_bus.cpu_addr = addr;
    cpu_bus.cpu_din  = din;
    stalls = 0;
    #3;
    while (cpu_bus.cpu_stall && stalls < 300) begin
      stalls++;
      @(posedge clk);
      #4;
    end
    if (stalls >= 300) begin
      n_total++;
      $display("FAIL %s: stall did not drop within 300 cycles", name);
    end
    dout = cpu_bus.cpu_dout;
    tick();
    cpu_bus.cpu_ren = 1'b0;
    cpu_bus.cpu_wen = 1'b0;
  endtask

  typedef struct {
    string       name;
    logic        ren;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] din;
    logic        chk_dout;
    logic [31:0] exp_dout;
  } vec_t;

  vec_t        vecs [7];
  logic [31:0] exp_wb [4];
  int          stalls;
  logic [31:0] dout;
  int          base;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Resident-line hit vectors (line 0x40..0x4C after the first miss)
    vecs[0] = '{"hit_rd_44",  1'b1, 1'b0, 32'h44, 32'h0,          1'b1, 32'hC0DE_0044};
    vecs[1] = '{"hit_wr_48",  1'b0, 1'b1, 32'h48, 32'hDEAD_BEEF,  1'b0, 32'h0};
    vecs[2] = '{"hit_rd_48",  1'b1, 1'b0, 32'h48, 32'h0,          1'b1, 32'hDEAD_BEEF};
    vecs[3] = '{"hit_rd_4c",  1'b1, 1'b0, 32'h4F, 32'h0,          1'b1, 32'hC0DE_004C};
    vecs[4] = '{"hit_rdwr_40",1'b1, 1'b1, 32'h40, 32'h1234_5678,  1'b0, 32'h0};
    vecs[5] = '{"hit_rd_40",  1'b1, 1'b0, 32'h40, 32'h0,          1'b1, 32'h1234_5678};
    vecs[6] = '{"hit_rd_44b", 1'b1, 1'b0, 32'h45, 32'h0,          1'b1, 32'hC0DE_0044};
    exp_wb = '{32'h1234_5678, 32'hC0DE_0044, 32'hDEAD_BEEF, 32'hC0DE_004C};

    cpu_bus.cpu_ren  = 1'b0;
    cpu_bus.cpu_wen  = 1'b0;
    cpu_bus.cpu_addr = '0;
    cpu_bus.cpu_din  = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    #3;
    check("rst_stall",    {31'd0, cpu_bus.cpu_stall}, 32'd0);
    check("rst_dout",     cpu_bus.cpu_dout, 32'd0);
    check("rst_mem_cs",   {31'd0, mem_bus.mem_cs}, 32'd0);
    check("rst_mem_we",   {31'd0, mem_bus.mem_we}, 32'd0);
    check("rst_mem_addr", mem_bus.mem_addr, 32'd0);
    check("rst_mem_dout", mem_bus.mem_dout, 32'd0);
    tick();

    // Cold miss: 1 + 4 beats of stall, reads 0x40..0x4C
    base = log_we.size();
    run_req("miss_40", 1'b1, 1'b0, 32'h40, 32'h0, stalls, dout);
    check("miss_40_stall", stalls, 32'd5);
    check("miss_40_dout",  dout, 32'hC0DE_0040);
    check("miss_40_beats", log_we.size() - base, 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (base + i < log_we.size()) begin
        check("miss_40_we",   {31'd0, log_we[base+i]}, 32'd0);
        check("miss_40_addr", log_addr[base+i], 32'h40 + 32'(4*i));
      end
    end

    // Hit table: zero stall, no memory traffic
    base = log_we.size();
    foreach (vecs[i]) begin
      run_req(vecs[i].name, vecs[i].ren, vecs[i].wen, vecs[i].addr, vecs[i].din, stalls, dout);
      check({vecs[i].name, "_stall"}, stalls, 32'd0);
      if (vecs[i].chk_dout) check({vecs[i].name, "_dout"}, dout, vecs[i].exp_dout);
    end
    check("hits_no_beats", log_we.size() - base, 32'd0);

    // Dirty eviction: 4 write-backs then 4 fills
    base = log_we.size();
    run_req("evict_440", 1'b1, 1'b0, 32'h440, 32'h0, stalls, dout);
    check("evict_stall", stalls, 32'd9);
    check("evict_dout",  dout, 32'hC0DE_0440);
    check("evict_beats", log_we.size() - base, 32'd8);
    for (int i = 0; i < 4; i++) begin
      if (base + 4 + i < log_we.size()) begin
        check("wb_we",     {31'd0, log_we[base+i]}, 32'd1);
        check("wb_addr",   log_addr[base+i], 32'h40 + 32'(4*i));
        check("wb_data",   log_data[base+i], exp_wb[i]);
        check("fill_we",   {31'd0, log_we[base+4+i]}, 32'd0);
        check("fill_addr", log_addr[base+4+i], 32'h440 + 32'(4*i));
      end
    end

    // Clean victim: written-back data now comes from memory
    base = log_we.size();
    run_req("refetch_40", 1'b1, 1'b0, 32'h40, 32'h0, stalls, dout);
    check("refetch_stall", stalls, 32'd5);
    check("refetch_dout",  dout, 32'h1234_5678);
    check("refetch_beats", log_we.size() - base, 32'd4);
    if (log_we.size() > base) check("refetch_no_wb", {31'd0, log_we[base]}, 32'd0);

    // Three-cycle memory: 1 + 4*3 stall cycles, beats held stable
    lat = 3;
    held_err = 0;
    run_req("slow_1000", 1'b1, 1'b0, 32'h1000, 32'h0, stalls, dout);
    check("slow_stall", stalls, 32'd13);
    check("slow_dout",  dout, 32'hC0DE_1000);
    check("slow_held",  held_err, 32'd0);

`ifdef DCACHE_STAT_EN
    check("stat_hit",  stat_hit,  32'd7);
    check("stat_miss", stat_miss, 32'd4);
`endif

    // Reset during the second fill beat
    base = log_we.size();
    cpu_bus.cpu_ren  = 1'b1;
    cpu_bus.cpu_addr = 32'h2000;
    begin
      int k;
      for (k = 0; k < 50 && log_we.size() < base + 1; k++) tick();
      if (log_we.size() < base + 1) begin
        n_total++;
        $display("FAIL rst_fill: first beat not seen within 50 cycles");
      end
    end
    check("rst_fill_cs_before",   {31'd0, mem_bus.mem_cs}, 32'd1);
    check("rst_fill_addr_before", mem_bus.mem_addr, 32'h2004);
    rst = 1'b1;
    cpu_bus.cpu_ren = 1'b0;
    tick();
    rst = 1'b0;
    #3;
    check("rst_fill_cs_after", {31'd0, mem_bus.mem_cs}, 32'd0);
    tick();

    base = log_we.size();
    run_req("refill_2000", 1'b1, 1'b0, 32'h2000, 32'h0, stalls, dout);
    check("refill_stall", stalls, 32'd13);
    check("refill_dout",  dout, 32'hC0DE_2000);
    check("refill_beats", log_we.size() - base, 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (base + i < log_we.size()) check("refill_addr", log_addr[base+i], 32'h2000 + 32'(4*i));
    end

`ifdef DCACHE_STAT_EN
    check("stat_hit_rst",  stat_hit,  32'd0);
    check("stat_miss_rst", stat_miss, 32'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
